hazard_fwd_unit: RTL and testbench

Parametrised hazard/forwarding unit for the pipelined RISC-V core. It generalises plain EX-stage operand forwarding to NUM_SRC source operands. It adds load-use stall detection and a tracker for one in-flight multi-cycle op (MUL/DIV) with a fixed-latency countdown. Placement: between the ID/EX and EX/MEM pipeline registers; it drives the EX operand muxes, the PC/IF-ID hold and the ID/EX bubble.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/mc_tracker.sv | 83 ++++++++
 rtl/hazard_fwd_unit.sv | 133 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/forwarding unit:
//   - forward-select encodings driven onto the EX operand muxes
//   - multi-cycle tracker state enum
//   - counter-width helper for the multi-cycle latency countdown
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } mc_state_e;

   // Bits needed to hold the countdown start value (latency - 2), at least 1.
   function automatic int unsigned mc_cnt_width(input int unsigned latency);
      if (latency <= 32'd2) begin
         return 1;
      end
      return $clog2(latency - 32'd1);
   endfunction

   localparam int unsigned MC_CNT_W_DEFAULT = mc_cnt_width(32'd4);

endpackage

// File: rtl/mc_tracker.sv
// mc_tracker
//   Tracks one in-flight multi-cycle (MUL/DIV) op with a fixed-latency countdown.
//   An accepted issue enters BUSY for MC_LATENCY-1 cycles, then DONE for one
//   cycle, so mc_done shows MC_LATENCY cycles after the issue cycle.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; drops any in-flight op
//   issue     accept a new op this cycle (already qualified by stall)
//   issue_rd  destination register of the issued op
//   mc_busy   op in flight (BUSY or DONE)
//   mc_done   result writes back this cycle
//   mc_wb_rd  destination for mc_done (0 otherwise)
//   mc_rd     latched destination, used for hazard compares
module mc_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MC_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  mc_busy,
   output logic                  mc_done,
   output logic [REG_ADDR_W-1:0] mc_wb_rd,
   output logic [REG_ADDR_W-1:0] mc_rd
);

   localparam int unsigned CntW = mc_cnt_width(MC_LATENCY);
   localparam logic [CntW-1:0] CntInit = CntW'(MC_LATENCY - 2);

   mc_state_e             state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StBusy;
               cnt_d   = CntInit;
               rd_d    = issue_rd;
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode registered state only.
   assign mc_busy  = (state_q != StIdle);
   assign mc_done  = (state_q == StDone);
   assign mc_wb_rd = (state_q == StDone) ? rd_q : '0;
   assign mc_rd    = rd_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   EX-stage operand forwarding for NUM_SRC sources, load-use stall detection
//   and hazard checks against one in-flight multi-cycle op.
//   Optional build macro: HAZARD_PERF_CNT_EN adds stall_cnt_lu / stall_cnt_mc.
// Ports:
//   clk, rst                         clock; synchronous active-high reset
//   id_rs, id_rs_used                ID-stage sources (src0 in LSBs), per-source used flag
//   id_rd, id_regwrite, id_mc_issue  ID-stage destination, write enable, multi-cycle op
//   ex_rs, ex_rd, ex_regwrite, ex_memread   ID/EX sources, destination, write enable, load
//   mem_rd, mem_regwrite             EX/MEM destination and write enable
//   wb_rd, wb_regwrite               MEM/WB destination and write enable
//   fwd_sel                          2 bits per source: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall, bubble                    hold PC/IF-ID, zero ID/EX control
//   mc_busy, mc_done, mc_wb_rd       multi-cycle tracker status
//   stall_cnt_lu, stall_cnt_mc       (HAZARD_PERF_CNT_EN) stall cycle counters
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned MC_LATENCY = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]         id_rd,
   input  logic                          id_regwrite,
   input  logic                          id_mc_issue,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0]         ex_rd,
   input  logic                          ex_regwrite,
   input  logic                          ex_memread,
   input  logic [REG_ADDR_W-1:0]         mem_rd,
   input  logic                          mem_regwrite,
   input  logic [REG_ADDR_W-1:0]         wb_rd,
   input  logic                          wb_regwrite,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          stall,
   output logic                          bubble,
   output logic                          mc_busy,
   output logic                          mc_done,
   output logic [REG_ADDR_W-1:0]         mc_wb_rd
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                   stall_cnt_lu,
   output logic [31:0]                   stall_cnt_mc
`endif
);

   logic [2*NUM_SRC-1:0]  fwd_raw;
   logic [NUM_SRC-1:0]    lu_src;
   logic [NUM_SRC-1:0]    mc_src;
   logic [REG_ADDR_W-1:0] mc_rd;
   logic                  lu_haz;
   logic                  mc_haz;
   logic                  hazard;
   logic                  mc_issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] ex_src;
      logic [REG_ADDR_W-1:0] id_src;
      logic                  mem_hit;
      logic                  wb_hit;

      assign ex_src  = ex_rs[i*REG_ADDR_W +: REG_ADDR_W];
      assign id_src  = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src);
      assign wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == ex_src);

      // EX/MEM holds the younger result, so it wins over MEM/WB.
      assign fwd_raw[2*i +: 2] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);

      assign lu_src[i] = id_rs_used[i] && (id_src == ex_rd);
      assign mc_src[i] = id_rs_used[i] && (id_src == mc_rd);
   end

   assign lu_haz = ex_memread && ex_regwrite && (ex_rd != '0) && (|lu_src);

   // Compares against the tracked destination stay live through DONE, so a
   // dependent is released only once the tracker is back in IDLE.
   assign mc_haz = mc_busy &&
                   (((mc_rd != '0) && (|mc_src)) ||
                    (id_regwrite && (id_rd == mc_rd)) ||
                    id_mc_issue);

   assign hazard = lu_haz || mc_haz;

   assign stall   = !rst && hazard;
   assign bubble  = stall;
   assign fwd_sel = rst ? '0 : fwd_raw;

   // A blocked issue is simply re-presented by the held ID stage.
   assign mc_issue = id_mc_issue && !hazard;

   mc_tracker #(
      .REG_ADDR_W (REG_ADDR_W),
      .MC_LATENCY (MC_LATENCY)
   ) u_mc_tracker (
      .clk      (clk),
      .rst      (rst),
      .issue    (mc_issue),
      .issue_rd (id_rd),
      .mc_busy  (mc_busy),
      .mc_done  (mc_done),
      .mc_wb_rd (mc_wb_rd),
      .mc_rd    (mc_rd)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] cnt_lu_q;
   logic [31:0] cnt_mc_q;

   // A cycle with both hazards counts in both counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_lu_q <= '0;
         cnt_mc_q <= '0;
      end else begin
         if (lu_haz) begin
            cnt_lu_q <= cnt_lu_q + 32'd1;
         end
         if (mc_haz) begin
            cnt_mc_q <= cnt_mc_q + 32'd1;
         end
      end
   end

   assign stall_cnt_lu = cnt_lu_q;
   assign stall_cnt_mc = cnt_mc_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed bench for hazard_fwd_unit (REG_ADDR_W=5, NUM_SRC=2, MC_LATENCY=4).
//   Honors HAZARD_PERF_CNT_EN when the design is built with it.
module tb_hazard_fwd_unit;

   logic       clk;
   logic       rst;
   logic [9:0] id_rs;
   logic [1:0] id_rs_used;
   logic [4:0] id_rd;
   logic       id_regwrite;
   logic       id_mc_issue;
   logic [9:0] ex_rs;
   logic [4:0] ex_rd;
   logic       ex_regwrite;
   logic       ex_memread;
   logic [4:0] mem_rd;
   logic       mem_regwrite;
   logic [4:0] wb_rd;
   logic       wb_regwrite;
   logic [3:0] fwd_sel;
   logic       stall;
   logic       bubble;
   logic       mc_busy;
   logic       mc_done;
   logic [4:0] mc_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_lu;
   logic [31:0] stall_cnt_mc;
`endif

   int total;
   int bad;

   hazard_fwd_unit #(
      .REG_ADDR_W (5),
      .NUM_SRC    (2),
      .MC_LATENCY (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_mc_issue  (id_mc_issue),
      .ex_rs        (ex_rs),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd_sel      (fwd_sel),
      .stall        (stall),
      .bubble       (bubble),
      .mc_busy      (mc_busy),
      .mc_done      (mc_done),
      .mc_wb_rd     (mc_wb_rd)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt_lu (stall_cnt_lu),
      .stall_cnt_mc (stall_cnt_mc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs        = '0;
      id_rs_used   = '0;
      id_rd        = '0;
      id_regwrite  = 1'b0;
      id_mc_issue  = 1'b0;
      ex_rs        = '0;
      ex_rd        = '0;
      ex_regwrite  = 1'b0;
      ex_memread   = 1'b0;
      mem_rd       = '0;
      mem_regwrite = 1'b0;
      wb_rd        = '0;
      wb_regwrite  = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      clear_inputs();
      step();
      step();

      // Reset: outputs low even with matching forward / load-use inputs.
      ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1;
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
      id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      #1;
      check("rst_fwd", fwd_sel, 4'b0000);
      check("rst_stall", stall, 1'b0);
      check("rst_bubble", bubble, 1'b0);
      check("rst_busy", mc_busy, 1'b0);
      check("rst_done", mc_done, 1'b0);
      check("rst_wbrd", mc_wb_rd, 5'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("rst_cnt_lu", stall_cnt_lu, 32'd0);
      check("rst_cnt_mc", stall_cnt_mc, 32'd0);
`endif
      clear_inputs();
      rst = 1'b0;
      step();

      // Forwarding vectors.
      ex_rs = {5'd2, 5'd1}; mem_rd = 5'd3; wb_rd = 5'd4;
      mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      #1;
      check("fwd_none", fwd_sel, 4'b0000);
      check("fwd_none_stall", stall, 1'b0);
      ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; wb_rd = 5'd5;
      #1;
      check("fwd_mem_beats_wb", fwd_sel, 4'b0010);
      mem_regwrite = 1'b0;
      #1;
      check("fwd_wb", fwd_sel, 4'b0001);
      mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = {5'd0, 5'd0};
      #1;
      check("fwd_x0", fwd_sel, 4'b0000);
      ex_rs = {5'd4, 5'd5}; mem_rd = 5'd5; wb_rd = 5'd4;
      #1;
      check("fwd_mixed", fwd_sel, 4'b0110);
      ex_rs = {5'd3, 5'd3}; mem_rd = 5'd3; wb_rd = 5'd3;
      #1;
      check("fwd_both_mem", fwd_sel, 4'b1010);
      clear_inputs();

      // Load-use.
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
      id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      #1;
      check("lu_stall", stall, 1'b1);
      check("lu_bubble", bubble, 1'b1);
      step();
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;  // bubble in ID/EX
      #1;
      check("lu_released", stall, 1'b0);
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs_used = 2'b00;
      #1;
      check("lu_unused", stall, 1'b0);
      id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      #1;
      check("lu_src1", stall, 1'b1);
      ex_rd = 5'd0; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
      #1;
      check("lu_x0", stall, 1'b0);
      clear_inputs();
      step();

      // Multi-cycle op, dependent on src1 waits until after mc_done.
      id_mc_issue = 1'b1; id_rd = 5'd9; id_regwrite = 1'b1;
      #1;
      check("mc_issue_nostall", stall, 1'b0);
      step();
      id_mc_issue = 1'b0; id_regwrite = 1'b0; id_rd = 5'd0;
      id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check($sformatf("mc1_busy_c%0d", k), mc_busy, (k <= 4) ? 1'b1 : 1'b0);
         check($sformatf("mc1_done_c%0d", k), mc_done, (k == 4) ? 1'b1 : 1'b0);
         check($sformatf("mc1_wbrd_c%0d", k), mc_wb_rd, (k == 4) ? 5'd9 : 5'd0);
         check($sformatf("mc1_dep_stall_c%0d", k), stall, (k <= 4) ? 1'b1 : 1'b0);
         step();
      end
      clear_inputs();

      // Second issue while busy, plus WAW.
      id_mc_issue = 1'b1; id_rd = 5'd9; id_regwrite = 1'b1;
      step();
      id_rd = 5'd10;
      #1;
      check("mc2_struct_stall", stall, 1'b1);
      id_mc_issue = 1'b0; id_rd = 5'd9;
      #1;
      check("mc2_waw_stall", stall, 1'b1);
      id_rd = 5'd11;
      #1;
      check("mc2_nodep", stall, 1'b0);
      id_mc_issue = 1'b1; id_rd = 5'd10;
      step();
      for (int k = 2; k <= 5; k++) begin
         #1;
         check($sformatf("mc2_hold_stall_c%0d", k), stall, (k <= 4) ? 1'b1 : 1'b0);
         check($sformatf("mc2_done_c%0d", k), mc_done, (k == 4) ? 1'b1 : 1'b0);
         check($sformatf("mc2_busy_c%0d", k), mc_busy, (k <= 4) ? 1'b1 : 1'b0);
         step();
      end
      id_mc_issue = 1'b0; id_regwrite = 1'b0; id_rd = 5'd0;
      for (int k = 6; k <= 10; k++) begin
         #1;
         check($sformatf("mc3_busy_c%0d", k), mc_busy, (k <= 9) ? 1'b1 : 1'b0);
         check($sformatf("mc3_done_c%0d", k), mc_done, (k == 9) ? 1'b1 : 1'b0);
         check($sformatf("mc3_wbrd_c%0d", k), mc_wb_rd, (k == 9) ? 5'd10 : 5'd0);
         step();
      end
      clear_inputs();

      // Issue blocked by load-use, retried and accepted once stall drops.
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
      id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      id_mc_issue = 1'b1; id_rd = 5'd12; id_regwrite = 1'b1;
      #1;
      check("lu_block_stall", stall, 1'b1);
      step();
      check("lu_block_not_taken", mc_busy, 1'b0);
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
      #1;
      check("lu_block_retry", stall, 1'b0);
      step();
      check("lu_block_taken", mc_busy, 1'b1);
      id_mc_issue = 1'b0; id_regwrite = 1'b0; id_rd = 5'd0;

      // Both hazards at once still give a single stall.
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd12;
      id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
      #1;
      check("both_stall", stall, 1'b1);
      check("both_bubble", bubble, 1'b1);
      clear_inputs();

      // Reset mid-op drops it; no mc_done afterwards.
      rst = 1'b1;
      step();
      check("midrst_busy", mc_busy, 1'b0);
      check("midrst_done", mc_done, 1'b0);
      check("midrst_stall", stall, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("midrst_nodone_%0d", k), mc_done, 1'b0);
      end
`ifdef HAZARD_PERF_CNT_EN
      check("midrst_cnt_lu", stall_cnt_lu, 32'd0);
      check("midrst_cnt_mc", stall_cnt_mc, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
